// File: rtl/stepper_move_sequencer_if.sv
// Command, control and driver-side signals of one axis move sequencer.
// master: axis executor plus driver/limit environment; slave: the sequencer.
interface stepper_move_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STEP_W     = 20,
  parameter int unsigned FEED_W     = 20
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              CmdValid;
  logic              CmdReady;
  logic [STEP_W-1:0] CmdStepCount;
  logic [FEED_W-1:0] CmdFeedRate;
  logic              CmdDirection;
  logic              Abort;
  logic              FaultClear;
  logic              LimitStart;
  logic              LimitEnd;
  logic              DrvStepWrite;
  logic [STEP_W-1:0] DrvStepCount;
  logic [FEED_W-1:0] DrvFeedRate;
  logic              DrvDirection;
  logic              DrvWaiting;
  logic              MoveDone;
  logic              Busy;
  logic [1:0]        FaultCode;
  logic [LVL_W-1:0]  QueueLevel;

  modport master (
    output CmdValid, CmdStepCount, CmdFeedRate, CmdDirection,
    output Abort, FaultClear, LimitStart, LimitEnd, DrvWaiting,
    input  CmdReady, DrvStepWrite, DrvStepCount, DrvFeedRate, DrvDirection,
    input  MoveDone, Busy, FaultCode, QueueLevel
  );

  modport slave (
    input  CmdValid, CmdStepCount, CmdFeedRate, CmdDirection,
    input  Abort, FaultClear, LimitStart, LimitEnd, DrvWaiting,
    output CmdReady, DrvStepWrite, DrvStepCount, DrvFeedRate, DrvDirection,
    output MoveDone, Busy, FaultCode, QueueLevel
  );
endinterface

// File: rtl/stepper_move_sequencer.sv
// Per-axis move sequencer: queues move commands and hands them one at a time
// to a Stepper_Driver over a level StepWrite / Waiting handshake.
module stepper_move_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STEP_W      = 20,
  parameter int unsigned FEED_W      = 20,
  parameter int unsigned ACK_TIMEOUT = 2000000
) (
  input logic                   Clock100Mhz,
  input logic                   Reset,
  stepper_move_sequencer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrMax  = TmrW'(ACK_TIMEOUT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  localparam logic [1:0] FaultNone    = 2'd0;
  localparam logic [1:0] FaultTimeout = 2'd1;
  localparam logic [1:0] FaultLimit   = 2'd2;
  localparam logic [1:0] FaultAbort   = 2'd3;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StFault} state_e;

  typedef struct packed {
    logic [STEP_W-1:0] steps;
    logic [FEED_W-1:0] feed;
    logic              dir;
  } cmd_t;

  state_e            state_q;
  cmd_t              mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [TmrW-1:0]   tmr_q;
  logic              step_write_q, move_done_q, drv_dir_q;
  logic [STEP_W-1:0] drv_step_q;
  logic [FEED_W-1:0] drv_feed_q;
  logic [1:0]        fault_q;

  cmd_t head;
  logic push, pop, timeout_hit, limit_hit, flush, cmd_ready;

  // Queue handshake and the conditions that throw the block into FAULT.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    cmd_ready   = (level_q != LvlFull) && (state_q != StFault);
    push        = bus.CmdValid && cmd_ready;
    pop         = (state_q == StLoad) && !bus.Abort;
    timeout_hit = (state_q == StStart) && bus.DrvWaiting && (tmr_q == TmrMax);
    // Only a limit ahead of the direction of travel matters; the driver gates the rest.
    limit_hit   = (state_q == StRun) && (drv_dir_q ? bus.LimitEnd : bus.LimitStart);
    flush       = bus.Abort || timeout_hit || limit_hit;
  end

  // Command storage; contents need no reset since the level gates every read.
  always_ff @(posedge Clock100Mhz) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{steps: bus.CmdStepCount, feed: bus.CmdFeedRate, dir: bus.CmdDirection};
    end
  end

  // Queue pointers and level; a flush discards everything including a same-cycle push.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Move FSM with registered driver outputs, completion pulse and fault code.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      step_write_q <= 1'b0;
      move_done_q  <= 1'b0;
      drv_step_q   <= '0;
      drv_feed_q   <= '0;
      drv_dir_q    <= 1'b0;
      fault_q      <= FaultNone;
    end else begin
      move_done_q <= 1'b0;
      if (bus.Abort) begin
        state_q      <= StFault;
        step_write_q <= 1'b0;
        fault_q      <= FaultAbort;
      end else begin
        case (state_q)
          StIdle: begin
            if ((level_q != '0) && bus.DrvWaiting && (fault_q == FaultNone)) state_q <= StLoad;
          end
          StLoad: begin
            drv_step_q <= head.steps;
            drv_feed_q <= head.feed;
            drv_dir_q  <= head.dir;
            tmr_q      <= '0;
            if (head.steps == '0) begin
              move_done_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              step_write_q <= 1'b1;
              state_q      <= StStart;
            end
          end
          StStart: begin
            if (!bus.DrvWaiting) begin
              step_write_q <= 1'b0;
              state_q      <= StRun;
            end else if (timeout_hit) begin
              step_write_q <= 1'b0;
              fault_q      <= FaultTimeout;
              state_q      <= StFault;
            end else begin
              tmr_q <= tmr_q + TmrW'(1);
            end
          end
          StRun: begin
            if (limit_hit) begin
              fault_q <= FaultLimit;
              state_q <= StFault;
            end else if (bus.DrvWaiting) begin
              move_done_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          StFault: begin
            step_write_q <= 1'b0;
            if (bus.FaultClear) begin
              fault_q <= FaultNone;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.CmdReady     = cmd_ready;
  assign bus.DrvStepWrite = step_write_q;
  assign bus.DrvStepCount = drv_step_q;
  assign bus.DrvFeedRate  = drv_feed_q;
  assign bus.DrvDirection = drv_dir_q;
  assign bus.MoveDone     = move_done_q;
  assign bus.Busy         = (state_q != StIdle) || (level_q != '0);
  assign bus.FaultCode    = fault_q;
  assign bus.QueueLevel   = level_q;
endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Self-checking bench for stepper_move_sequencer: directed fault scenarios plus
// randomized command streams checked against a transaction-level queue model.
module tb_stepper_move_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 20;
  localparam int unsigned FW    = 20;
  localparam int unsigned TMO   = 40;

  typedef struct packed {
    logic [SW-1:0] steps;
    logic [FW-1:0] feed;
    logic          dir;
  } cmd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stepper_move_sequencer_if #(.FIFO_DEPTH(DEPTH), .STEP_W(SW), .FEED_W(FW)) bus ();

  stepper_move_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .STEP_W     (SW),
    .FEED_W     (FW),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .Clock100Mhz(clk),
    .Reset      (rst_n),
    .bus        (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sw_rise_cyc = 0;
  int fault1_cyc = 0;
  int drv_mode = 0;  // 0 acks, 1 busy (Waiting low), 2 deaf (Waiting high), 3 acks and holds
  cmd_t exp_q[$];
  cmd_t sw_log[$];
  logic [SW-1:0] done_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: logs completions and StepWrite rises, timestamps timeout faults.
  initial begin
    logic       prev_sw;
    logic [1:0] prev_fault;
    prev_sw    = 1'b0;
    prev_fault = 2'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.MoveDone === 1'b1) done_log.push_back(bus.DrvStepCount);
      if (bus.DrvStepWrite === 1'b1 && prev_sw !== 1'b1) begin
        sw_log.push_back({bus.DrvStepCount, bus.DrvFeedRate, bus.DrvDirection});
        sw_rise_cyc = cyc;
      end
      if (bus.FaultCode === 2'd1 && prev_fault !== 2'd1) fault1_cyc = cyc;
      prev_sw    = bus.DrvStepWrite;
      prev_fault = bus.FaultCode;
    end
  end

  // Driver model: acknowledges StepWrite after a random delay, runs a random time.
  initial begin
    bus.DrvWaiting = 1'b1;
    forever begin
      tick();
      case (drv_mode)
        1: bus.DrvWaiting = 1'b0;
        2: bus.DrvWaiting = 1'b1;
        default: begin
          if (bus.DrvStepWrite && bus.DrvWaiting) begin
            repeat ($urandom_range(0, 2)) tick();
            bus.DrvWaiting = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            while (drv_mode == 3) tick();
            bus.DrvWaiting = 1'b1;
          end else begin
            bus.DrvWaiting = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    sw_log.delete();
    done_log.delete();
  endtask

  task automatic push_cmd(input cmd_t c, output logic acc);
    bus.CmdValid = 1'b1;
    {bus.CmdStepCount, bus.CmdFeedRate, bus.CmdDirection} = c;
    @(negedge clk);
    acc = bus.CmdReady;
    tick();
    bus.CmdValid = 1'b0;
  endtask

  task automatic push_ready(input cmd_t c);
    int   n;
    logic acc;
    n = 0;
    while (!bus.CmdReady && n < 500) begin
      tick();
      n++;
    end
    check_eq("push_ready", 64'(bus.CmdReady), 64'd1);
    push_cmd(c, acc);
    exp_q.push_back(c);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while (done_log.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(done_log.size() >= n), 64'd1);
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!(bus.Busy && !bus.DrvWaiting && !bus.DrvStepWrite) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(n < 200), 64'd1);
  endtask

  // Every queued command completes in order; only non-zero ones raise StepWrite.
  task automatic check_logs(input string tag);
    int k;
    k = 0;
    check_eq({tag, "_ndone"}, 64'(done_log.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < done_log.size()) check_eq({tag, "_done_order"}, 64'(done_log[i]), 64'(exp_q[i].steps));
      if (exp_q[i].steps != '0) begin
        if (k < sw_log.size()) begin
          check_eq({tag, "_drv_steps"}, 64'(sw_log[k].steps), 64'(exp_q[i].steps));
          check_eq({tag, "_drv_feed"}, 64'(sw_log[k].feed), 64'(exp_q[i].feed));
          check_eq({tag, "_drv_dir"}, 64'(sw_log[k].dir), 64'(exp_q[i].dir));
        end
        k++;
      end
    end
    check_eq({tag, "_nwrite"}, 64'(sw_log.size()), 64'(k));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(bus.CmdReady), 64'd1);
    check_eq({tag, "_sw"}, 64'(bus.DrvStepWrite), 64'd0);
    check_eq({tag, "_steps"}, 64'(bus.DrvStepCount), 64'd0);
    check_eq({tag, "_feed"}, 64'(bus.DrvFeedRate), 64'd0);
    check_eq({tag, "_dir"}, 64'(bus.DrvDirection), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.MoveDone), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.Busy), 64'd0);
    check_eq({tag, "_fault"}, 64'(bus.FaultCode), 64'd0);
    check_eq({tag, "_level"}, 64'(bus.QueueLevel), 64'd0);
  endtask

  task automatic pulse_clear();
    bus.FaultClear = 1'b1;
    tick();
    bus.FaultClear = 1'b0;
  endtask

  initial begin
    cmd_t c;
    logic acc;
    int   lvl;
    int   n;

    bus.CmdValid     = 1'b0;
    bus.CmdStepCount = '0;
    bus.CmdFeedRate  = '0;
    bus.CmdDirection = 1'b0;
    bus.Abort        = 1'b0;
    bus.FaultClear   = 1'b0;
    bus.LimitStart   = 1'b0;
    bus.LimitEnd     = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // Three-command sequence including a zero-step move.
    clear_logs();
    push_ready('{steps: 20'd100, feed: 20'd5, dir: 1'b1});
    push_ready('{steps: 20'd0, feed: 20'd5, dir: 1'b0});
    push_ready('{steps: 20'd7, feed: 20'd9, dir: 1'b0});
    wait_done("seq3_wait", 3);
    repeat (5) tick();
    check_logs("seq3");
    check_eq("seq3_nwrite2", 64'(sw_log.size()), 64'd2);

    // Randomized streams with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      for (int i = 0; i < 7; i++) begin
        c.steps = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom_range(1, 1000));
        c.feed  = FW'($urandom());
        c.dir   = 1'($urandom_range(0, 1));
        push_ready(c);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_done("rnd_wait", 7);
      repeat (5) tick();
      check_logs("rnd");
      check_eq("rnd_idle_busy", 64'(bus.Busy), 64'd0);
      check_eq("rnd_idle_level", 64'(bus.QueueLevel), 64'd0);
    end

    // Stalled driver: queue fills at DEPTH, the extra command is dropped.
    clear_logs();
    drv_mode = 1;
    repeat (2) tick();
    lvl = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      c.steps = SW'($urandom_range(1, 500));
      c.feed  = FW'($urandom_range(1, 100));
      c.dir   = 1'($urandom_range(0, 1));
      push_cmd(c, acc);
      check_eq("full_ready", 64'(acc), 64'(lvl < DEPTH));
      if (lvl < DEPTH) begin
        exp_q.push_back(c);
        lvl++;
      end
    end
    check_eq("full_level", 64'(bus.QueueLevel), 64'(DEPTH));
    check_eq("full_ready_low", 64'(bus.CmdReady), 64'd0);
    check_eq("full_busy", 64'(bus.Busy), 64'd1);
    drv_mode = 0;
    wait_done("full_wait", DEPTH);
    repeat (20) tick();
    check_logs("full");

    // Deaf driver: ack timeout exactly TMO cycles after START entry.
    clear_logs();
    drv_mode = 2;
    push_ready('{steps: 20'd33, feed: 20'd4, dir: 1'b1});
    push_ready('{steps: 20'd44, feed: 20'd4, dir: 1'b0});
    repeat (3) tick();
    check_eq("tmo_start_sw", 64'(bus.DrvStepWrite), 64'd1);
    check_eq("tmo_start_level", 64'(bus.QueueLevel), 64'd1);
    n = 0;
    while (bus.FaultCode == 2'd0 && n < int'(TMO) + 50) begin
      tick();
      n++;
    end
    tick();
    check_eq("tmo_code", 64'(bus.FaultCode), 64'd1);
    check_eq("tmo_latency", 64'(fault1_cyc - sw_rise_cyc), 64'(TMO));
    check_eq("tmo_sw", 64'(bus.DrvStepWrite), 64'd0);
    check_eq("tmo_level", 64'(bus.QueueLevel), 64'd0);
    check_eq("tmo_ready", 64'(bus.CmdReady), 64'd0);
    check_eq("tmo_hold_steps", 64'(bus.DrvStepCount), 64'd33);
    check_eq("tmo_ndone", 64'(done_log.size()), 64'd0);
    drv_mode = 0;
    pulse_clear();
    check_eq("tmo_clr_code", 64'(bus.FaultCode), 64'd0);
    check_eq("tmo_clr_busy", 64'(bus.Busy), 64'd0);
    check_eq("tmo_clr_ready", 64'(bus.CmdReady), 64'd1);

    // Limit: opposite end ignored, end in travel direction faults.
    clear_logs();
    drv_mode = 3;
    push_ready('{steps: 20'd50, feed: 20'd2, dir: 1'b1});
    wait_run("lim_run");
    bus.LimitStart = 1'b1;
    repeat (5) tick();
    check_eq("lim_opp_code", 64'(bus.FaultCode), 64'd0);
    check_eq("lim_opp_busy", 64'(bus.Busy), 64'd1);
    bus.LimitStart = 1'b0;
    bus.LimitEnd   = 1'b1;
    repeat (2) tick();
    check_eq("lim_code", 64'(bus.FaultCode), 64'd2);
    check_eq("lim_sw", 64'(bus.DrvStepWrite), 64'd0);
    check_eq("lim_ready", 64'(bus.CmdReady), 64'd0);
    bus.LimitEnd = 1'b0;
    drv_mode = 0;
    repeat (4) tick();
    check_eq("lim_ndone", 64'(done_log.size()), 64'd0);
    pulse_clear();
    check_eq("lim_clr_code", 64'(bus.FaultCode), 64'd0);
    check_eq("lim_clr_busy", 64'(bus.Busy), 64'd0);

    // Abort during RUN with two commands queued.
    clear_logs();
    drv_mode = 3;
    for (int i = 0; i < 3; i++) begin
      c.steps = SW'($urandom_range(1, 500));
      c.feed  = FW'($urandom_range(1, 100));
      c.dir   = 1'b0;
      push_ready(c);
    end
    wait_run("abt_run");
    check_eq("abt_pre_level", 64'(bus.QueueLevel), 64'd2);
    bus.Abort = 1'b1;
    tick();
    check_eq("abt_code", 64'(bus.FaultCode), 64'd3);
    check_eq("abt_level", 64'(bus.QueueLevel), 64'd0);
    check_eq("abt_sw", 64'(bus.DrvStepWrite), 64'd0);
    check_eq("abt_ready", 64'(bus.CmdReady), 64'd0);
    pulse_clear();
    tick();
    check_eq("abt_clr_ignored", 64'(bus.FaultCode), 64'd3);
    bus.Abort = 1'b0;
    drv_mode = 0;
    repeat (3) tick();
    check_eq("abt_held", 64'(bus.FaultCode), 64'd3);
    pulse_clear();
    check_eq("abt_clr_code", 64'(bus.FaultCode), 64'd0);
    check_eq("abt_clr_busy", 64'(bus.Busy), 64'd0);
    check_eq("abt_ndone", 64'(done_log.size()), 64'd0);

    // Reset asserted while StepWrite is held in START.
    clear_logs();
    drv_mode = 2;
    push_ready('{steps: 20'd30, feed: 20'd3, dir: 1'b1});
    n = 0;
    while (!bus.DrvStepWrite && n < 50) begin
      tick();
      n++;
    end
    check_eq("mid_rst_start", 64'(bus.DrvStepWrite), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n    = 1'b1;
    drv_mode = 0;
    tick();
    check_reset_outputs("mid_rst_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
